// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 32-step shift/add-subtract
// datapath. An FSM sequences it and applies the sign correction at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH, S_DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    counter;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] opnd, hi, lo, spec_val_q;
  logic             neg_res, neg_rem, special_q;

  // Accept-time operand decode
  logic             accept, is_div_in, div_signed, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] mag_a, mag_b, spec_val;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    accept     = START && !FLUSH && !BUSY;
    is_div_in  = FUNCT3[2];
    div_signed = ~FUNCT3[0];
    a_signed   = is_div_in ? div_signed : (FUNCT3[1:0] == 2'b01 || FUNCT3[1:0] == 2'b10);
    b_signed   = is_div_in ? div_signed : (FUNCT3[1:0] == 2'b01);
    a_neg      = a_signed && DATA1[WIDTH-1];
    b_neg      = b_signed && DATA2[WIDTH-1];
    mag_a      = a_neg ? -DATA1 : DATA1;
    mag_b      = b_neg ? -DATA2 : DATA2;
    div_zero   = is_div_in && (DATA2 == '0);
    div_ovf    = is_div_in && div_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
    special    = div_zero || div_ovf;
    spec_val   = '0;
    if (div_zero)     spec_val = FUNCT3[1] ? DATA1 : '1;
    else if (div_ovf) spec_val = FUNCT3[1] ? '0 : MIN_NEG;
  end

  // One iteration of shift-add (multiply) or restoring subtract (divide)
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_borrow;

  always_comb begin
    mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift  = {hi, lo[WIDTH-1]};
    div_borrow = div_shift < {1'b0, opnd};
    div_diff   = div_shift[WIDTH-1:0] - opnd;
  end

  // Sign correction and result selection used in FINISH
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem, fin_val;

  always_comb begin
    prod_mag = {hi, lo};
    prod     = neg_res ? -prod_mag : prod_mag;
    quo      = neg_res ? -lo : lo;
    rem      = neg_rem ? -hi : hi;
    if (special_q)               fin_val = spec_val_q;
    else if (f3_q[2])            fin_val = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == 2'b00) fin_val = prod[WIDTH-1:0];
    else                         fin_val = prod[2*WIDTH-1:WIDTH];
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; FLUSH wins over everything except reset
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = special ? S_FINISH : S_CALC;
        else        state_next = S_IDLE;
      end
      S_CALC: begin
        if (FLUSH)                     state_next = S_IDLE;
        else if (counter == LAST_ITER) state_next = S_FINISH;
      end
      S_FINISH: state_next = FLUSH ? S_IDLE : S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    BUSY = (state == S_CALC) || (state == S_FINISH);
    DONE = (state == S_DONE);
  end

  // Datapath. NOTE: operand/accumulator registers are reloaded on every accept,
  // so only the counter and RESULT carry a reset value.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      counter <= '0;
      RESULT  <= '0;
    end else if (FLUSH) begin
      counter <= '0;
    end else if (accept) begin
      counter    <= '0;
      f3_q       <= FUNCT3;
      hi         <= '0;
      lo         <= is_div_in ? mag_a : mag_b;
      opnd       <= is_div_in ? mag_b : mag_a;
      neg_res    <= a_neg ^ b_neg;
      neg_rem    <= a_neg;
      special_q  <= special;
      spec_val_q <= spec_val;
    end else if (state == S_CALC) begin
      counter <= counter + 1'b1;
      if (f3_q[2]) begin
        hi <= div_borrow ? div_shift[WIDTH-1:0] : div_diff;
        lo <= {lo[WIDTH-2:0], ~div_borrow};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end else if (state == S_FINISH) begin
      RESULT <= fin_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special
// cases, flush, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] DATA1, DATA2;
  logic        FLUSH;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    FUNCT3 = f; DATA1 = a; DATA2 = b; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Called in the cycle after the accept edge; returns edges until DONE is seen.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!DONE && cycles < 100) begin
      if (BUSY) busy_cycles++;
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bsy;
    issue(f, a, b);
    wait_done(lat, bsy);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, RESULT, exp);
    tick();
    check({tag, "_done_clr"}, {31'b0, DONE}, 32'd0);
  endtask

  initial begin
    int lat, bsy;
    logic seen_done;

    RESET = 1'b0; START = 1'b1; FLUSH = 1'b0;
    FUNCT3 = MUL; DATA1 = 32'd3; DATA2 = 32'd4;
    tick();
    tick();
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_done", {31'b0, DONE}, 32'd0);
    check("rst_result", RESULT, 32'd0);
    START = 1'b0;
    RESET = 1'b1;
    tick();

    issue(MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bsy);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_busy_cycles", 32'(bsy), 32'd33);
    check("mul_res", RESULT, 32'hFFFF_FFEB);
    tick();
    check("mul_done_clr", {31'b0, DONE}, 32'd0);

    run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu", DIVU, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu", REMU, 32'd100,       32'd7, 32'd2,         33);

    run_op("divu_by0", DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0",  REM,  32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Back-to-back: second START presented during the DONE cycle
    issue(DIVU, 32'd100, 32'd7);
    wait_done(lat, bsy);
    check("b2b_first_res", RESULT, 32'd14);
    FUNCT3 = MULHU; DATA1 = 32'hFFFF_FFFF; DATA2 = 32'hFFFF_FFFF; START = 1'b1;
    tick();
    START = 1'b0;
    check("b2b_accepted_busy", {31'b0, BUSY}, 32'd1);
    check("b2b_first_hold", RESULT, 32'd14);
    wait_done(lat, bsy);
    check("b2b_second_lat", 32'(lat), 32'd33);
    check("b2b_second_res", RESULT, 32'hFFFF_FFFE);
    tick();

    // Flush at edge k+10 of a DIV, restart at k+11
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_busy", {31'b0, BUSY}, 32'd0);
    check("flush_done", {31'b0, DONE}, 32'd0);
    check("flush_result_hold", RESULT, 32'hFFFF_FFFE);
    run_op("after_flush", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

    // FLUSH and START together: not accepted
    FUNCT3 = DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
    START = 1'b1; FLUSH = 1'b1;
    tick();
    START = 1'b0; FLUSH = 1'b0;
    check("flush_start_busy", {31'b0, BUSY}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_done |= DONE;
      tick();
    end
    check("flush_start_no_done", {31'b0, seen_done}, 32'd0);
    check("flush_start_result", RESULT, 32'hFFFF_FFFF);

    // Operand changes during CALC must not affect the result
    issue(DIVU, 32'd100, 32'd7);
    tick();
    DATA1 = 32'h1234_5678; DATA2 = 32'd3; FUNCT3 = MUL;
    wait_done(lat, bsy);
    check("toggle_lat", 32'(lat + 1), 32'd33);
    check("toggle_res", RESULT, 32'd14);
    tick();

    // Reset in the middle of CALC
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("midrst_busy", {31'b0, BUSY}, 32'd0);
    check("midrst_result", RESULT, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_done |= DONE;
      tick();
    end
    check("midrst_no_done", {31'b0, seen_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
